// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe -- three-stage pipelined approximate unsigned multiplier.
//
// Each product bit column c = i+j collects the partial products a[i]&b[j].
// In approximate mode, the low APPROX_COLS columns are replaced by the OR of
// their bits, and carries out of those columns are dropped. All higher
// columns are summed exactly. Exact mode returns the true product a*b.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   in_valid/in_ready    operand handshake (in_a, in_b, in_mode)
//   in_mode              0 = exact, 1 = approximate
//   out_valid/out_ready  result handshake (out_p, out_hit)
//   out_hit              result differs from the exact product
//   hit_cnt              saturating count of transferred results with out_hit=1
//   cnt_clr              synchronous clear of hit_cnt (wins over increment)
module approx_mult_pipe #(
  parameter int WIDTH       = 6,
  parameter int APPROX_COLS = 4,
  parameter int CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               out_hit,
  output logic [CNT_W-1:0]   hit_cnt,
  input  logic               cnt_clr
);

  localparam int P_W = 2 * WIDTH;
  // Columns that use approximate (OR) compression.
  localparam logic [P_W-1:0] LO_MASK = (P_W'(1) << APPROX_COLS) - P_W'(1);

  // 3:2 carry-save compressor on whole rows. Returns {carry, sum}.
  function automatic logic [2*P_W-1:0] csa(input logic [P_W-1:0] x,
                                           input logic [P_W-1:0] y,
                                           input logic [P_W-1:0] z);
    logic [P_W-1:0] s;
    logic [P_W-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic             vld_p1, vld_p2, vld_p3;
  logic             adv1, adv2, adv3;

  logic [WIDTH-1:0] a_p1, b_p1;
  logic             mode_p1;

  logic [P_W-1:0]   sum_p2, car_p2;
  logic             hit_p2;

  logic [P_W-1:0]   sum_c, car_c;
  logic             hit_c;

  // A stage may move forward when its successor is empty or moving too.
  assign adv3      = !vld_p3 | out_ready;
  assign adv2      = !vld_p2 | adv3;
  assign adv1      = !vld_p1 | adv2;
  assign in_ready  = adv1;
  assign out_valid = vld_p3;

  // ---- Stage 1: operand capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else if (adv1) vld_p1 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      a_p1    <= in_a;
      b_p1    <= in_b;
      mode_p1 <= in_mode;
    end
  end

  // Partial-product reduction to two rows plus hit detection.
  always_comb begin
    logic [P_W-1:0]   row;
    logic [P_W-1:0]   seen;
    logic [P_W-1:0]   two;
    logic [P_W-1:0]   keep;
    logic [2*P_W-1:0] cs;
    seen  = '0;
    two   = '0;
    sum_c = '0;
    car_c = '0;
    hit_c = 1'b0;
    keep  = mode_p1 ? ~LO_MASK : '1;
    for (int i = 0; i < WIDTH; i++) begin
      row   = P_W'(a_p1 & {WIDTH{b_p1[i]}}) << i;
      // Bits of one row sit in distinct columns, so overlap with earlier
      // rows marks columns holding two or more set bits.
      two   = two | (seen & row);
      seen  = seen | row;
      cs    = csa(sum_c, car_c, row & keep);
      sum_c = cs[P_W-1:0];
      car_c = cs[2*P_W-1:P_W];
    end
    // The OR row only occupies the low columns, which are otherwise empty
    // in approximate mode, so no carry can arise from them.
    cs    = csa(sum_c, car_c, mode_p1 ? (seen & LO_MASK) : '0);
    sum_c = cs[P_W-1:0];
    car_c = cs[2*P_W-1:P_W];
    hit_c = mode_p1 & (|(two & LO_MASK));
  end

  // ---- Stage 2: reduced sum/carry rows ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p2 <= 1'b0;
    else if (adv2) vld_p2 <= vld_p1;
  end

  always_ff @(posedge clk) begin
    if (adv2 && vld_p1) begin
      sum_p2 <= sum_c;
      car_p2 <= car_c;
      hit_p2 <= hit_c;
    end
  end

  // ---- Stage 3: carry-propagate add into the output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p3  <= 1'b0;
      out_p   <= '0;
      out_hit <= 1'b0;
    end else if (adv3) begin
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        out_p   <= sum_p2 + car_p2;
        out_hit <= hit_p2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) hit_cnt <= '0;
    else if (cnt_clr) hit_cnt <= '0;
    else if (vld_p3 && out_ready && out_hit) hit_cnt <= sat_inc(hit_cnt);
  end

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe -- directed bench for approx_mult_pipe.
// Three instances share the stimulus: default parameters, CNT_W=2 for
// saturation, and APPROX_COLS=0 where approximate must equal exact.
module tb_approx_mult_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [5:0]  in_a, in_b;
  logic        in_mode;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready, out_valid, out_hit;
  logic [11:0] out_p;
  logic [15:0] hit_cnt;

  logic        in_ready2, out_valid2, out_hit2;
  logic [11:0] out_p2;
  logic [1:0]  hit_cnt2;

  logic        in_ready3, out_valid3, out_hit3;
  logic [11:0] out_p3;
  logic [15:0] hit_cnt3;

  int n_cmp = 0;
  int n_err = 0;

  approx_mult_pipe #(.WIDTH(6), .APPROX_COLS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_p(out_p), .out_hit(out_hit),
    .hit_cnt(hit_cnt), .cnt_clr(cnt_clr));

  approx_mult_pipe #(.WIDTH(6), .APPROX_COLS(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid2),
    .out_ready(out_ready), .out_p(out_p2), .out_hit(out_hit2),
    .hit_cnt(hit_cnt2), .cnt_clr(cnt_clr));

  approx_mult_pipe #(.WIDTH(6), .APPROX_COLS(0), .CNT_W(16)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .out_valid(out_valid3),
    .out_ready(out_ready), .out_p(out_p3), .out_hit(out_hit3),
    .hit_cnt(hit_cnt3), .cnt_clr(cnt_clr));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Send one pair, check latency and result, then let it transfer.
  task automatic run_one(input string tag, input logic [5:0] a, input logic [5:0] b,
                         input logic m, input logic [11:0] ep, input logic eh,
                         input logic clr);
    int n;
    logic [11:0] exact;
    exact = 12'(a) * 12'(b);
    in_a = a; in_b = b; in_mode = m; in_valid = 1'b1;
    check({tag, "_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_lat"}, n, 2);
    check({tag, "_p"}, out_p, ep);
    check({tag, "_hit"}, out_hit, eh);
    check({tag, "_p2"}, out_p2, ep);
    check({tag, "_p3"}, out_p3, exact);
    check({tag, "_hit3"}, out_hit3, 0);
    cnt_clr = clr;
    tick();
    cnt_clr = 1'b0;
  endtask

  // Hand-computed vectors for the default instance.
  logic [5:0]  va [8] = '{6'd10, 6'd63, 6'd3, 6'd7, 6'd5, 6'd2, 6'd15, 6'd7};
  logic [5:0]  vb [8] = '{6'd12, 6'd63, 6'd3, 6'd9, 6'd1, 6'd2, 6'd1,  6'd7};
  logic        vm [8] = '{1'b0,  1'b1,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1,  1'b1};
  logic [11:0] vp [8] = '{12'd120, 12'd3935, 12'd7, 12'd63, 12'd5, 12'd4, 12'd15, 12'd31};
  logic        vh [8] = '{1'b0,  1'b1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1};

  int sidx [4] = '{1, 2, 0, 6};

  initial begin
    int rx, sent, first, last, acc, q[$], k, cnt;
    logic took;
    logic [11:0] held_p;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    tick(); tick();
    check("rst_vld", out_valid, 0);
    check("rst_p", out_p, 0);
    check("rst_hit", out_hit, 0);
    check("rst_cnt", hit_cnt, 0);
    rst = 1'b0;
    tick();
    check("rst_rdy", in_ready, 1);

    // Single transactions.
    run_one("ex63", 6'd63, 6'd63, 1'b0, 12'd3969, 1'b0, 1'b0);
    run_one("ap63", 6'd63, 6'd63, 1'b1, 12'd3935, 1'b1, 1'b0);
    run_one("ap33", 6'd3, 6'd3, 1'b1, 12'd7, 1'b1, 1'b0);
    run_one("ap51", 6'd5, 6'd1, 1'b1, 12'd5, 1'b0, 1'b0);
    check("cnt_single", hit_cnt, 2);

    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr_cnt", hit_cnt, 0);

    // Back-to-back stream, one result per cycle.
    rx = 0; sent = 0; first = -1; last = -1;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      if (out_valid) begin
        check($sformatf("str%0d_p", rx), out_p, vp[rx]);
        check($sformatf("str%0d_hit", rx), out_hit, vh[rx]);
        if (first < 0) first = cyc;
        last = cyc;
        rx++;
      end
      if (sent < 8) begin
        in_a = va[sent]; in_b = vb[sent]; in_mode = vm[sent]; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      took = in_valid && in_ready;
      tick();
      if (took) sent++;
    end
    in_valid = 1'b0;
    check("str_count", rx, 8);
    check("str_gapless", last - first, 7);
    check("str_cnt", hit_cnt, 3);

    // Backpressure: fill while out_ready=0.
    out_ready = 1'b0;
    acc = 0; held_p = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      k = sidx[acc];
      in_a = va[k]; in_b = vb[k]; in_mode = vm[k]; in_valid = 1'b1;
      took = in_ready;
      if (took) q.push_back(k);
      tick();
      if (took) acc++;
      if (out_valid && cyc == 2) held_p = out_p;
    end
    check("stall_acc", acc, 3);
    check("stall_rdy", in_ready, 0);
    check("stall_vld", out_valid, 1);
    check("stall_held", out_p, held_p);
    check("stall_p", out_p, 3935);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rx = 0;
    for (int cyc = 0; cyc < 20 && rx < 3; cyc++) begin
      if (out_valid) begin
        k = q.pop_front();
        check($sformatf("drain%0d_p", rx), out_p, vp[k]);
        check($sformatf("drain%0d_hit", rx), out_hit, vh[k]);
        rx++;
      end
      tick();
    end
    check("drain_count", rx, 3);
    tick();
    check("drain_nodup", out_valid, 0);
    check("drain_cnt", hit_cnt, 5);
    check("drain_cnt2", hit_cnt2, 3);

    // Saturation and clear priority.
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    check("clr2_cnt", hit_cnt2, 0);
    for (int i = 0; i < 5; i++) run_one($sformatf("sat%0d", i), 6'd3, 6'd3, 1'b1, 12'd7, 1'b1, 1'b0);
    check("sat_cnt2", hit_cnt2, 3);
    check("sat_cnt", hit_cnt, 5);
    run_one("clrhit", 6'd3, 6'd3, 1'b1, 12'd7, 1'b1, 1'b1);
    check("clrhit_cnt", hit_cnt, 0);
    check("clrhit_cnt2", hit_cnt2, 0);

    // Reset with three entries in flight.
    run_one("prerst", 6'd63, 6'd63, 1'b1, 12'd3935, 1'b1, 1'b0);
    check("prerst_cnt", hit_cnt, 1);
    out_ready = 1'b0;
    in_a = 6'd63; in_b = 6'd63; in_mode = 1'b1; in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    check("fill_vld", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_vld", out_valid, 0);
    check("arst_cnt", hit_cnt, 0);
    check("arst_p", out_p, 0);
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    in_a = 6'd5; in_b = 6'd1; in_mode = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid) begin
        cnt++;
        check("post_p", out_p, 5);
      end
      tick();
    end
    check("post_count", cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
